// File: rtl/ervp_seq_divider.sv
// Iterative radix-2 restoring divider: signed/unsigned DIV and REM, one quotient bit per cycle.
// Optional ERVP_SEQ_DIVIDER_EARLY_OUT_EN: divisor 0 or +1 finishes in one cycle instead of N+1.
module ervp_seq_divider #(
    parameter int BW_DIVIDEND = 32,
    parameter int BW_DIVISOR  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [BW_DIVIDEND-1:0] req_dividend,
    input  logic [BW_DIVISOR-1:0]  req_divisor,
    input  logic                   req_signed,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BW_DIVIDEND-1:0] rsp_quotient,
    output logic [BW_DIVISOR-1:0]  rsp_remainder,
    output logic                   rsp_div_by_zero
);
    localparam int N  = BW_DIVIDEND;
    localparam int M  = BW_DIVISOR;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    dvd_q;     // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [M-1:0]    dvs_q;
    logic [M-1:0]    rem_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            dbz_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [N-1:0]    rsp_quotient_q;
    logic [M-1:0]    rsp_remainder_q;
    logic            rsp_dbz_q;

    logic [M:0]      rem_shift;
    logic [M+1:0]    diff;
    logic [M-1:0]    rem_d;
    logic [N-1:0]    dvd_d;
    logic            dvd_neg, dvs_neg, dvs_zero, dvs_one;
    logic [N-1:0]    dvd_mag;
    logic [M-1:0]    dvs_mag;
    logic [N-1:0]    q_fix;
    logic [M-1:0]    r_fix;
    logic            early_zero, early_one;

    // The working partial remainder is M+1 bits; after a successful subtract it is
    // always below the divisor, so only M bits need to be kept between cycles.
    always_comb begin
        rem_shift = {rem_q, dvd_q[N-1]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
        rem_d     = diff[M+1] ? rem_shift[M-1:0] : diff[M-1:0];
        dvd_d     = {dvd_q[N-2:0], ~diff[M+1]};
    end

    always_comb begin
        dvd_neg  = req_signed & req_dividend[N-1];
        dvs_neg  = req_signed & req_divisor[M-1];
        dvs_zero = (req_divisor == '0);
        dvs_one  = (req_divisor == M'(1));
        dvd_mag  = dvd_neg ? -req_dividend : req_dividend;
        dvs_mag  = dvs_neg ? -req_divisor : req_divisor;
        q_fix    = qneg_q ? -dvd_q : dvd_q;
        r_fix    = rneg_q ? -rem_q : rem_q;
    end

`ifdef ERVP_SEQ_DIVIDER_EARLY_OUT_EN
    assign early_zero = dvs_zero;
    assign early_one  = dvs_one;
`else
    assign early_zero = 1'b0;
    assign early_one  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dvd_q           <= '0;
            dvs_q           <= '0;
            rem_q           <= '0;
            qneg_q          <= 1'b0;
            rneg_q          <= 1'b0;
            dbz_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= CW'(N - 1);
                        dvs_q       <= dvs_mag;
                        dbz_q       <= dvs_zero;
                        rem_q       <= '0;
                        qneg_q      <= 1'b0;
                        rneg_q      <= 1'b0;
                        if (early_zero) begin
                            dvd_q   <= '1;
                            rem_q   <= req_dividend[M-1:0];
                            state_q <= FIX;
                        end else if (early_one) begin
                            dvd_q   <= req_dividend;
                            state_q <= FIX;
                        end else if (dvs_zero) begin
                            // Raw dividend and no sign fix-up: all-ones quotient and the
                            // truncated dividend as remainder fall out of the iteration.
                            dvd_q   <= req_dividend;
                            state_q <= CALC;
                        end else begin
                            dvd_q   <= dvd_mag;
                            qneg_q  <= dvd_neg ^ dvs_neg;
                            rneg_q  <= dvd_neg;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIX: begin
                    rsp_quotient_q  <= q_fix;
                    rsp_remainder_q <= r_fix;
                    rsp_dbz_q       <= dbz_q;
                    rsp_valid_q     <= 1'b1;
                    state_q         <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_quotient    = rsp_quotient_q;
    assign rsp_remainder   = rsp_remainder_q;
    assign rsp_div_by_zero = rsp_dbz_q;

endmodule

// File: tb/tb_ervp_seq_divider.sv
// Scoreboard bench for ervp_seq_divider (N=M=32): directed vectors, decoupled response monitor.
module tb_ervp_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor = '0;
    logic        req_signed = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_div_by_zero;

    ervp_seq_divider #(.BW_DIVIDEND(32), .BW_DIVISOR(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_by_zero(rsp_div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int LAT = 33;
`ifdef ERVP_SEQ_DIVIDER_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 33;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int unsigned lat;
        int unsigned acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: latency measured from accept edge to first cycle with rsp_valid high.
    initial begin
        bit seen = 0;
        int unsigned rise = 0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                seen = 0;
            end else begin
                if (rsp_valid && !seen) begin
                    seen = 1;
                    rise = cyc;
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rsp actual=%h required=none", rsp_quotient);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_q"}, rsp_quotient, e.q);
                        chk({e.name, "_r"}, rsp_remainder, e.r);
                        chk({e.name, "_dbz"}, {31'b0, rsp_div_by_zero}, {31'b0, e.dbz});
                        chk({e.name, "_lat"}, rise - e.acc, e.lat);
                    end
                    seen = 0;
                end
            end
        end
    end

    // Called just after a negedge; returns just after a negedge with acc = accept edge count.
    task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int unsigned elat, input bit push,
                          output int unsigned acc);
        exp_t e;
        int n = 0;
        req_dividend = a; req_divisor = b; req_signed = sgn; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk); n++;
        end
        acc = 0;
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL %s_accept_timeout actual=busy required=ready", name);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        req_dividend = $urandom; req_divisor = $urandom; req_signed = ~sgn;
        if (push) begin
            e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.acc = acc; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0 || !req_ready) begin
            total++; bad++;
            $display("FAIL %s_drain_timeout actual=%0d required=0", name, sb.size());
        end
    endtask

    initial begin
        int unsigned a;
        int unsigned c0;
        int busy_bad;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_q", rsp_quotient, 32'd0);
        chk("rst_r", rsp_remainder, 32'd0);
        chk("rst_dbz", {31'b0, rsp_div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 100/7, checking req_ready stays low while busy
        do_req("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT, 1, a);
        busy_bad = 0;
        for (int i = 0; i < 31; i++) begin
            if (req_ready) busy_bad++;
            @(negedge clk);
        end
        chk("u100_7_busy_ready", busy_bad, 32'd0);
        wait_idle("u100_7");

        do_req("s_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT, 1, a);
        wait_idle("s_m100_7");
        do_req("s100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, LAT, 1, a);
        wait_idle("s100_m7");
        do_req("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, LAT_EARLY, 1, a);
        wait_idle("u5_0");
        do_req("s5_0", 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1, LAT_EARLY, 1, a);
        wait_idle("s5_0");
        do_req("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, LAT, 1, a);
        wait_idle("s_ovf");
        do_req("u_max_2", 32'hFFFFFFFF, 32'd2, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, LAT, 1, a);
        wait_idle("u_max_2");
        do_req("u_div1", 32'd12345, 32'd1, 1'b0, 32'd12345, 32'd0, 1'b0, LAT_EARLY, 1, a);
        wait_idle("u_div1");
        do_req("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT, 1, a);
        wait_idle("s_m7_2");
        do_req("u_big_7", 32'hFFFFFFF9, 32'd7, 1'b0, 32'h24924923, 32'd4, 1'b0, LAT, 1, a);
        wait_idle("u_big_7");

        // Backpressure: result held 10 cycles while a second request waits
        rsp_ready = 1'b0;
        do_req("bp1", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, LAT, 1, a);
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        req_dividend = 32'd50; req_divisor = 32'd8; req_signed = 1'b0; req_valid = 1'b1;
        busy_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || req_ready || rsp_quotient !== 32'd100 || rsp_remainder !== 32'd0)
                busy_bad++;
            @(negedge clk);
        end
        chk("bp_hold_stable", busy_bad, 32'd0);
        c0 = cyc;
        rsp_ready = 1'b1;
        do_req("bp2", 32'd50, 32'd8, 1'b0, 32'd6, 32'd2, 1'b0, LAT, 1, a);
        chk("bp2_accept_cycle", a, c0 + 2);
        wait_idle("bp2");

        // Reset mid-operation: no response, then a fresh request works
        do_req("rst_op", 32'd77, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, LAT, 0, a);
        for (int i = 0; i < 14; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("postrst_req_ready", {31'b0, req_ready}, 32'd1);
        do_req("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, LAT, 1, a);
        wait_idle("u9_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
